fir_axil_ctrl: RTL
==================

// Module: fir_axil_ctrl
// PURPOSE
// AXI-Lite responder for the FIR accelerator's configuration space. Sits between the host AXI-Lite initiator and
// the FIR datapath, owning ap_ctrl (0x00), data_length (0x10) and the tap window (0x20..). Tap accesses go to the
// external tap BRAM, whose port is arbitrated with the FIR engine. Generates the engine start pulse and tracks done/idle.
// PARAMETERS
// pADDR_WIDTH  12  AXI-Lite and BRAM address width (byte addresses)
// pDATA_WIDTH  32  data width
// Tape_Num     11  number of taps; tap window = 0x20 .. 0x20+4*(Tape_Num-1)
// PORTS
// axis_clk    in   1   single clock
// axis_rst_n  in   1   asynchronous active-low reset
// awvalid/awaddr  in  1/12  write address; awready out 1
// wvalid/wdata    in  1/32  write data; wready out 1 (no B channel)
// arvalid/araddr  in  1/12  read address; arready out 1
// rready in 1; rvalid out 1; rdata out 32  read data channel
// tap_WE out 4; tap_EN out 1; tap_Di out 32; tap_A out 12; tap_Do in 32  tap BRAM port (1-cycle read latency)
// eng_tap_EN in 1; eng_tap_A in 12  engine tap read request, honoured only while busy
// eng_start  out 1   one-cycle start pulse to the FIR engine
// eng_done   in  1   one-cycle pulse: last output beat accepted on the stream sink
// data_length out 32 current data_length register
// eng_busy   out 1   high from eng_start until eng_done
// BEHAVIOUR
// Reset: awready=wready=arready=rvalid=0, rdata=0, tap_WE=0, tap_EN=0, eng_start=0, eng_busy=0, data_length=0.
//   ap_ctrl resets to 0x4 (idle=1).
// Write FSM W_IDLE->W_ACK->W_GAP->W_IDLE:
//   W_IDLE: both awvalid and wvalid high -> latch addr/data -> W_ACK.
//   W_ACK: awready=wready=1 for exactly one cycle; the register/BRAM write is committed here -> W_GAP.
//   W_GAP: one dead cycle so a still-high valid is not re-accepted. awvalid without wvalid, or vice versa: wait.
// Read FSM R_IDLE->R_ADDR->R_DATA:
//   R_ADDR: arready=1 for one cycle; issue tap BRAM read if in tap window.
//   R_DATA: rvalid=1 with rdata stable until rready; then -> R_IDLE.
//   arvalid seen at edge N -> arready at N+1 -> rvalid at N+2, uniformly for every address.
// Register map:
//   0x00 ap_ctrl: bit0 ap_start W1, bit1 ap_done, bit2 ap_idle; bits[31:3] read 0.
//     Writing bit0=1 while idle: eng_start pulses the next cycle, bit0 reads 1 for that cycle only,
//     idle->0, done->0, eng_busy->1. Writing bit0=1 while busy is ignored.
//     eng_done: idle->1, done->1, eng_busy->0.
//     A completed read of 0x00 (rvalid&rready) clears done; a same-cycle eng_done wins (done stays 1).
//   0x10 data_length: R/W; writes while busy are ignored.
//   Tap window, k<Tape_Num: tap_A = awaddr-0x20 (byte address 4k). Write drives tap_EN=1, tap_WE=4'hF, tap_Di=wdata.
//     Reads use tap_EN=1, tap_WE=0 and return tap_Do.
//   Any other address: writes are acknowledged and dropped; reads return 0.
// Tap port arbitration:
//   Busy: engine owns the port (tap_A=eng_tap_A, tap_EN=eng_tap_EN, tap_WE=0).
//     AXI tap writes are acked and dropped; AXI tap reads return 32'hFFFF_FFFF.
//   Idle: AXI owns the port. A write (W_ACK) and a read (R_ADDR) in the same cycle: the write proceeds and the
//     read stalls one cycle in R_ADDR with arready held low.
// Reset mid-transaction aborts both FSMs to IDLE and all outputs to reset values. Latched tap BRAM contents are untouched.
// TESTING
// 1) Write 0x10=600, read 0x10 -> rdata=600; arready 1 cycle after arvalid, rvalid 1 cycle later.
// 2) Write taps {0,-10,-9,23,56,63,56,23,-9,-10,0} at 0x20..0x48, read back -> exact values; tap_A=0x00..0x28.
// 3) Write 0x00=1 while idle -> one eng_start pulse; read 0x00 -> 0x0. Second write while busy -> no pulse.
// 4) Pulse eng_done; read 0x00 -> 0x6; read again -> 0x4 (done cleared on read).
// 5) Busy: write tap 0x24=99 -> acked, BRAM unchanged; read 0x24 -> 0xFFFFFFFF; write 0x10=5 -> still 600.
// 6) Hold awvalid/wvalid high 3 cycles -> exactly one accept; assert axis_rst_n=0 in R_DATA -> rvalid=0, ap_ctrl=0x4.

Source files
------------

// File: rtl/fir_axil_ctrl.sv
// AXI-Lite configuration responder for the FIR accelerator.
// Owns ap_ctrl, data_length and the tap window; arbitrates the tap BRAM port.
module fir_axil_ctrl #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   awvalid,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   output logic                   awready,
   input  logic                   wvalid,
   input  logic [pDATA_WIDTH-1:0] wdata,
   output logic                   wready,
   input  logic                   arvalid,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   arready,
   input  logic                   rready,
   output logic                   rvalid,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   input  logic                   eng_tap_EN,
   input  logic [pADDR_WIDTH-1:0] eng_tap_A,
   output logic                   eng_start,
   input  logic                   eng_done,
   output logic [pDATA_WIDTH-1:0] data_length,
   output logic                   eng_busy
);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_ACK  = 2'd1;
   localparam logic [1:0] W_GAP  = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_ADDR = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   localparam logic [pADDR_WIDTH-1:0] A_CTRL = '0;
   localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(16);
   localparam logic [pADDR_WIDTH-1:0] A_TAP0 = pADDR_WIDTH'(32);
   localparam logic [pADDR_WIDTH-1:0] A_TAPN =
      pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

   logic [1:0]             w_state_q, w_state_d;
   logic [pADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]             r_state_q, r_state_d;
   logic [pADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                   tap_pend_q, tap_pend_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   eng_start_q, eng_start_d;
   logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;

   logic                   w_commit;
   logic                   w_tap;
   logic                   r_tap;
   logic                   r_stall;
   logic                   r_done;
   logic [pDATA_WIDTH-1:0] ctrl_word;

   function automatic logic in_tap(input logic [pADDR_WIDTH-1:0] a);
      return (a >= A_TAP0) && (a <= A_TAPN);
   endfunction

   assign w_commit  = (w_state_q == W_ACK);
   assign w_tap     = w_commit && in_tap(waddr_q);
   assign r_tap     = (r_state_q == R_ADDR) && in_tap(raddr_q);
   assign r_stall   = r_tap && !busy_q && w_commit;
   assign r_done    = (r_state_q == R_DATA) && rready;
   assign ctrl_word = {{(pDATA_WIDTH-3){1'b0}}, !busy_q, done_q, eng_start_q};

   assign awready     = w_commit;
   assign wready      = w_commit;
   assign arready     = (r_state_q == R_ADDR) && !r_stall;
   assign rvalid      = (r_state_q == R_DATA);
   assign rdata       = tap_pend_q ? tap_Do : rdata_q;
   assign eng_start   = eng_start_q;
   assign eng_busy    = busy_q;
   assign data_length = data_length_q;

   always_comb begin
      w_state_d = w_state_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (awvalid && wvalid) begin
               waddr_d   = awaddr;
               wdata_d   = wdata;
               w_state_d = W_ACK;
            end
         end
         W_ACK:   w_state_d = W_GAP;
         default: w_state_d = W_IDLE;
      endcase
   end

   // rdata is captured when the address is accepted; tap data lands a cycle later
   always_comb begin
      r_state_d  = r_state_q;
      raddr_d    = raddr_q;
      rdata_d    = rdata_q;
      tap_pend_d = tap_pend_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               raddr_d   = araddr;
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (!r_stall) begin
               r_state_d  = R_DATA;
               tap_pend_d = 1'b0;
               if (r_tap) begin
                  if (busy_q) rdata_d = '1;
                  else tap_pend_d = 1'b1;
               end else if (raddr_q == A_CTRL) begin
                  rdata_d = ctrl_word;
               end else if (raddr_q == A_LEN) begin
                  rdata_d = data_length_q;
               end else begin
                  rdata_d = '0;
               end
            end
         end
         default: begin
            if (tap_pend_q) begin
               rdata_d    = tap_Do;
               tap_pend_d = 1'b0;
            end
            if (rready) r_state_d = R_IDLE;
         end
      endcase
   end

   always_comb begin
      busy_d        = busy_q;
      done_d        = done_q;
      eng_start_d   = 1'b0;
      data_length_d = data_length_q;
      if (w_commit && !busy_q) begin
         if (waddr_q == A_LEN) data_length_d = wdata_q;
         if (waddr_q == A_CTRL && wdata_q[0]) begin
            eng_start_d = 1'b1;
            busy_d      = 1'b1;
            done_d      = 1'b0;
         end
      end
      if (r_done && raddr_q == A_CTRL) done_d = 1'b0;
      if (eng_done) begin
         busy_d = 1'b0;
         done_d = 1'b1;
      end
   end

   always_comb begin
      tap_EN = 1'b0;
      tap_WE = 4'h0;
      tap_A  = '0;
      tap_Di = wdata_q;
      if (busy_q) begin
         tap_EN = eng_tap_EN;
         tap_A  = eng_tap_A;
      end else if (w_tap) begin
         tap_EN = 1'b1;
         tap_WE = 4'hF;
         tap_A  = waddr_q - A_TAP0;
      end else if (r_tap) begin
         tap_EN = 1'b1;
         tap_A  = raddr_q - A_TAP0;
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         w_state_q     <= W_IDLE;
         waddr_q       <= '0;
         wdata_q       <= '0;
         r_state_q     <= R_IDLE;
         raddr_q       <= '0;
         rdata_q       <= '0;
         tap_pend_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         eng_start_q   <= 1'b0;
         data_length_q <= '0;
      end else begin
         w_state_q     <= w_state_d;
         waddr_q       <= waddr_d;
         wdata_q       <= wdata_d;
         r_state_q     <= r_state_d;
         raddr_q       <= raddr_d;
         rdata_q       <= rdata_d;
         tap_pend_q    <= tap_pend_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         eng_start_q   <= eng_start_d;
         data_length_q <= data_length_d;
      end
   end

endmodule
